// File: rtl/trit_pack_ctrl.sv
// trit_pack_ctrl: packs up to five base-3 digits (trits) into one byte,
// out_byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4, through a 4-cycle
// serial accumulate.
// Optional build macro TRIT_PACK_CHECK_EN: when defined, err becomes a
// sticky flag raised by an accepted illegal trit code (2'b11). When the
// macro is undefined, err is tied low. In both builds an illegal trit
// is packed as 0.
module trit_pack_ctrl #(
  parameter int N_BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_trit,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_byte,
  output logic                out_last,
  output logic [N_BYTE_W-1:0] out_cnt,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, COLLECT, CONV, OUT} state_t;

  state_t              r_state;
  logic [1:0]          r_t [4];     // t0..t3; t4 goes straight into the accumulator
  logic [2:0]          r_idx;       // trits accepted so far in this group
  logic [1:0]          r_count;     // CONV step counter
  logic [7:0]          r_acc;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_last_grp;  // group was closed by in_last
  logic                r_done;
  logic [N_BYTE_W-1:0] r_cnt;

  logic       w_accept;
  logic       w_close;
  logic       w_hs;
  logic [1:0] w_tv;
  logic [7:0] w_t4;
  logic [7:0] w_x [4];
  logic [7:0] w_x_sel;

  assign w_accept = in_valid & r_in_ready;
  assign w_close  = w_accept & ((r_idx == 3'd4) | in_last);
  assign w_hs     = r_out_valid & out_ready;
  // Illegal code 11 contributes nothing to the packed value.
  assign w_tv     = (in_trit == 2'b11) ? 2'b00 : in_trit;
  assign w_t4     = {6'd0, w_tv} * 8'd81;

  // Weighted terms x[k] = 3^k * t_k, added one per CONV cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_weight
      localparam logic [7:0] WEIGHT = 8'(3 ** gi);
      assign w_x[gi] = {6'd0, r_t[gi]} * WEIGHT;
    end
  endgenerate

  assign w_x_sel = w_x[r_count];

  // Main control FSM: collect trits, serially accumulate, hand the byte out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      for (int k = 0; k < 4; k++) r_t[k] <= 2'b00;
      r_idx       <= 3'd0;
      r_count     <= 2'd0;
      r_acc       <= 8'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_last_grp  <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, COLLECT: begin
          if (w_close) begin
            // A 5th trit lands in acc directly; an early close leaves t4 = 0.
            r_acc <= (r_idx == 3'd4) ? w_t4 : 8'd0;
            if (r_idx != 3'd4) r_t[r_idx[1:0]] <= w_tv;
            r_count    <= 2'd0;
            r_last_grp <= in_last;
            r_in_ready <= 1'b0;
            r_state    <= CONV;
          end else if (w_accept) begin
            r_t[r_idx[1:0]] <= w_tv;
            r_idx           <= r_idx + 3'd1;
            r_state         <= COLLECT;
          end
        end
        CONV: begin
          r_acc   <= r_acc + w_x_sel;
          r_count <= r_count + 2'd1;
          if (r_count == 2'd3) begin
            r_state     <= OUT;
            r_out_valid <= 1'b1;
            r_out_last  <= r_last_grp;
          end
        end
        OUT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_idx       <= 3'd0;
            for (int k = 0; k < 4; k++) r_t[k] <= 2'b00;
            if (r_out_last) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= COLLECT;
              r_cnt   <= r_cnt + N_BYTE_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TRIT_PACK_CHECK_EN
  logic r_err;

  // Sticky illegal-trit flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                                  r_err <= 1'b0;
    else if (w_accept && in_trit == 2'b11)    r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_acc;
  assign out_last  = r_out_last;
  assign out_cnt   = r_cnt;
  assign done      = r_done;

endmodule

// File: tb/tb_trit_pack_ctrl.sv
// Scoreboard bench for trit_pack_ctrl: a driver pushes expected bytes
// computed from the packing rule, a monitor pops and compares them on
// every output handshake and also tracks out_cnt, done and hold-stability.
module tb_trit_pack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_trit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic [7:0] out_cnt;
  logic       done;
  logic       err;

  trit_pack_ctrl #(.N_BYTE_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_trit(in_trit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .out_cnt(out_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q [$];   // {last, byte}
  logic [1:0] trits [$];
  bit         hold = 1'b1;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: split the polynomial into groups of five, weight by powers of 3.
  task automatic push_expected();
    int n = trits.size();
    for (int g = 0; g < n; g += 5) begin
      int sum = 0;
      int p = 1;
      for (int k = 0; k < 5; k++) begin
        if (g + k < n) sum += ((trits[g+k] == 2'd3) ? 0 : int'(trits[g+k])) * p;
        p *= 3;
      end
      exp_q.push_back({(g + 5 >= n) ? 1'b1 : 1'b0, 8'(sum)});
    end
  endtask

  // Present one trit; returns at posedge+1 after it was accepted.
  task automatic send(input logic [1:0] t, input bit last);
    int n = 0;
    in_valid = 1'b1; in_trit = t; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) chk(1'b0, "in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    $display("trit %0d last=%0d accepted", t, last);
  endtask

  task automatic send_poly(input bit push);
    if (push) push_expected();
    for (int i = 0; i < trits.size(); i++) send(trits[i], i == trits.size() - 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Consumer back-pressure, updated after the driver's posedge+1 slot.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares handshakes against the scoreboard, tracks out_cnt/done.
  initial begin
    logic [7:0] mcnt;
    bit         exp_done;
    bit         prev_stall;
    logic [7:0] prev_byte;
    logic       prev_last;
    logic [8:0] e;
    mcnt = 0; exp_done = 0; prev_stall = 0; prev_byte = 0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mcnt = 0; exp_done = 0; prev_stall = 0;
        continue;
      end
      chk(done == exp_done, "done", done, exp_done);
      chk(out_cnt == mcnt, "out_cnt", out_cnt, mcnt);
      if (prev_stall) begin
        chk(out_valid == 1'b1, "stall_valid", out_valid, 1);
        chk(out_byte == prev_byte, "stall_byte", out_byte, prev_byte);
        chk(out_last == prev_last, "stall_last", out_last, prev_last);
      end
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_byte", out_byte, -1);
        end else begin
          e = exp_q.pop_front();
          $display("byte %0d last=%0d (expected %0d last=%0d) cnt=%0d",
                   out_byte, out_last, e[7:0], e[8], out_cnt);
          chk(out_byte == e[7:0], "out_byte", out_byte, e[7:0]);
          chk(out_last == e[8], "out_last", out_last, e[8]);
          exp_done = e[8];
          mcnt = e[8] ? 8'd0 : mcnt + 8'd1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      prev_last  = out_last;
    end
  end

  initial begin
    logic [7:0] rec;
    int         n;
    rst = 1'b1; in_valid = 1'b0; in_trit = 2'd0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(out_valid == 0, "rst_out_valid", out_valid, 0);
    chk(out_byte == 0, "rst_out_byte", out_byte, 0);
    chk(out_last == 0, "rst_out_last", out_last, 0);
    chk(out_cnt == 0, "rst_out_cnt", out_cnt, 0);
    chk(done == 0, "rst_done", done, 0);
    chk(err == 0, "rst_err", err, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk(in_ready == 1, "rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Five ones closed by in_last on the 5th: 121, output latency 4 cycles.
    trits = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    send_poly(1'b1);
    repeat (4) @(negedge clk);
    chk(out_valid == 0, "latency_early", out_valid, 0);
    @(negedge clk);
    chk(out_valid == 1, "latency_4", out_valid, 1);
    @(posedge clk); #1; hold = 1'b0;
    wait_drain();

    // Two groups: 102 then 242 (last).
    trits = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    send_poly(1'b1);
    wait_drain();

    // Back-pressure for 10 cycles while the next trit is waiting.
    hold = 1'b1;
    trits = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    fork
      send_poly(1'b1);
      begin
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk(out_valid == 1, "hold_wait", out_valid, 1);
        rec = out_byte;
        repeat (10) begin
          @(negedge clk);
          chk(out_valid == 1, "hold_valid", out_valid, 1);
          chk(out_byte == rec, "hold_byte", out_byte, rec);
          chk(in_ready == 0, "hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1; hold = 1'b0;
      end
    join
    wait_drain();

    // 701 random trits: 141 bytes, the last one holding t700 alone.
    trits.delete();
    for (int i = 0; i < 701; i++) trits.push_back(2'($urandom_range(0, 2)));
    send_poly(1'b1);
    wait_drain();

    // Reset while CONV is at count 2: that byte must vanish.
    trits = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    send_poly(1'b0);
    @(posedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk(out_valid == 0, "rst_conv_no_byte", out_valid, 0);
    end
    @(posedge clk); #1;
    trits = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    send_poly(1'b1);
    wait_drain();

    // Illegal trit packs as 0: 1,11,1,0,0 -> 10.
    chk(err == 0, "err_before", err, 0);
    trits = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd0};
    send_poly(1'b1);
    wait_drain();
`ifdef TRIT_PACK_CHECK_EN
    chk(err == 1, "err_sticky", err, 1);
`else
    chk(err == 0, "err_tied", err, 0);
`endif
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk(err == 0, "err_rst", err, 0);
    chk(in_ready == 1, "in_ready_after_rst", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trit_pack_ctrl.md
TRIT_PACK_CTRL -- requirements
Module: trit_pack_ctrl

Interface
REQ-001 SHALL have parameter N_BYTE_W, default 8: width of the out_cnt byte counter.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_trit/in_last valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a trit this cycle.
REQ-006 SHALL have port in_trit  input  2  trit code: 00=0, 01=1, 10=2, 11=illegal.
REQ-007 SHALL have port in_last  input  1  final coefficient of the polynomial.
REQ-008 SHALL have port out_valid  output  1  out_byte valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_byte.
REQ-010 SHALL have port out_byte  output  8  packed byte.
REQ-011 SHALL have port out_last  output  1  out_byte is the polynomial's final byte.
REQ-012 SHALL have port out_cnt  output  N_BYTE_W  bytes emitted since last done/reset.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last byte is accepted.
REQ-014 SHALL have port err  output  1  sticky illegal-trit flag.

Function
REQ-015 SHALL pack trits t0..t4, in arrival order, as out_byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4; maximum value 242, no overflow.
REQ-016 SHALL use FSM states IDLE, COLLECT, CONV, OUT; IDLE->COLLECT on in_valid; COLLECT->CONV on group close; CONV->OUT after 4 cycles; OUT->COLLECT on handshake unless out_last; OUT->IDLE on handshake with out_last.
REQ-017 SHALL assert in_ready only in IDLE and COLLECT; a trit is accepted on in_valid & in_ready; IDLE accepts the first trit directly.
REQ-018 SHALL close a group at the edge accepting its 5th trit or a trit with in_last=1; missing trits SHALL be zero.
REQ-019 SHALL, at the closing edge, load acc = 81*t4 and count = 0; in CONV, each edge SHALL add x[count] (t0, 3*t1, 9*t2, 27*t3 for count 0..3) and increment count, mod 4.
REQ-020 SHALL assert out_valid exactly 4 edges after the closing edge; latency from last trit accepted to out_valid is 4 cycles.
REQ-021 SHALL hold out_byte, out_last and out_valid stable while out_valid & !out_ready.
REQ-022 SHALL set out_last=1 only for the byte from a group closed by in_last.
REQ-023 SHALL increment out_cnt on each output handshake, wrapping mod 2^N_BYTE_W; on the handshake with out_last, done SHALL pulse 1 cycle later and out_cnt SHALL clear to 0 in the same cycle.
REQ-024 SHALL accept in_last on a 5th trit as a single close, not an additional empty group.
REQ-025 SHALL keep in_ready=0 from the closing edge until the output handshake; no input buffering.

Reset
REQ-026 SHALL, with rst=1 at an edge, set state IDLE, acc/count/trit group/out_cnt 0, out_valid/out_last/done/err 0, out_byte 0, in_ready 1 after release.
REQ-027 SHALL let rst override any state, including mid-CONV and OUT; the in-flight byte is discarded and never emitted.

Configuration
REQ-028 SHALL use macro TRIT_PACK_CHECK_EN: defined -> accepted in_trit=11 is packed as 0 and sets err, held until rst; undefined -> 11 is packed as 0 and err is tied 0.

Verification
REQ-029 SHALL cover: trits 1,1,1,1,1 with in_last on 5th -> one byte 121, out_last=1, out_valid 4 cycles after 5th accept, done 1 cycle after handshake.
REQ-030 SHALL cover: trits 0,1,2,0,1 then 2,2,2,2,2 (last) -> bytes 102 then 242, out_cnt 1 then 0 after done.
REQ-031 SHALL cover: 701 random trits, in_last on 701st -> 141 bytes matching the reference model; 141st byte = t700 only, out_last=1.
REQ-032 SHALL cover: out_ready held 0 for 10 cycles in OUT -> out_byte stable, in_ready=0 throughout, no trit lost.
REQ-033 SHALL cover: rst asserted at CONV count=2 -> no byte emitted, next group 2,0,0,0,0 (last) -> byte 2.
REQ-034 SHALL cover: in_trit=11 among 1,11,1,0,0 -> byte 10; err=1 only with TRIT_PACK_CHECK_EN defined.
